// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with a registered one-hot
// grant, a guaranteed one-cycle gap between owners and, when the macro
// ARB_HOLD_LIMIT_EN is defined, forced release of an owner that has held the
// grant for MAX_HOLD cycles while another requester is waiting.
module rr_arbiter4 #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [1:0]   gnt_id,
  output logic         gnt_valid,
  output logic         preempt
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     owner_q, owner_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [1:0]     pick;
  logic           any_req;
  logic           hold_sat;
`ifdef ARB_HOLD_LIMIT_EN
  logic           preempt_q, preempt_d;
  logic           others_req;
`endif

  // Round-robin search: first set request at or after ptr, wrapping modulo 4.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = ptr_q + i[1:0];
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign any_req  = |req;
  assign hold_sat = (hold_q == HW'(MAX_HOLD));

`ifdef ARB_HOLD_LIMIT_EN
  assign others_req = |(req & ~(N'(1) << owner_q));
`endif

  // Next-state and next-output logic for the IDLE/GRANT/GAP machine.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
`ifdef ARB_HOLD_LIMIT_EN
    preempt_d = 1'b0;
`endif
    unique case (state_q)
      S_IDLE, S_GAP: begin
        if (any_req) begin
          state_d = S_GRANT;
          owner_d = pick;
          gnt_d   = N'(1) << pick;
          hold_d  = HW'(1);
        end else begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (!req[owner_q]) begin
          state_d = S_GAP;
          gnt_d   = '0;
          ptr_d   = owner_q + 2'd1;
`ifdef ARB_HOLD_LIMIT_EN
        end else if (hold_sat && others_req) begin
          state_d   = S_GAP;
          gnt_d     = '0;
          ptr_d     = owner_q + 2'd1;
          preempt_d = 1'b1;
`endif
        end else if (!hold_sat) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers; asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
`ifdef ARB_HOLD_LIMIT_EN
      preempt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
`ifdef ARB_HOLD_LIMIT_EN
      preempt_q <= preempt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = owner_q;
  assign gnt_valid = |gnt_q;
`ifdef ARB_HOLD_LIMIT_EN
  assign preempt   = preempt_q;
`else
  assign preempt   = 1'b0;
`endif

endmodule
